// File: rtl/text_cursor.sv
// Write-side engine for the text-mode VRAM: places printable bytes at the cursor,
// handles CR/LF/BS, line wrap and scrolling, and clears the screen/rows with BLANK.
module text_cursor #(
    parameter int          COLS  = 100,
    parameter int          ROWS  = 30,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] in_char_i,
    output logic [4:0] top_row_o,
    output logic [4:0] cursor_row_o,
    output logic [6:0] cursor_col_o,
    output logic       vram_we_o,
    output logic [4:0] vram_row_o,
    output logic [6:0] vram_col_o,
    output logic [7:0] vram_char_o
);

    // state       | meaning
    // S_CLEAR_ALL | blanking the whole VRAM after reset, one cell per cycle
    // S_IDLE      | accepting bytes, in_ready high
    // S_CLEAR_ROW | blanking the row exposed by a scroll
    typedef enum logic [1:0] {
        S_CLEAR_ALL,
        S_IDLE,
        S_CLEAR_ROW
    } state_t;

    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
    localparam logic [5:0] ROWS_W   = 6'(ROWS);

    state_t     state_q, state_d;
    logic [4:0] clr_row_q, clr_row_d;
    logic [6:0] clr_col_q, clr_col_d;
    logic [4:0] top_row_q, top_row_d;
    logic [4:0] cursor_row_q, cursor_row_d;
    logic [6:0] cursor_col_q, cursor_col_d;
    logic       in_ready_q, in_ready_d;
    logic       vram_we_q, vram_we_d;
    logic [4:0] vram_row_q, vram_row_d;
    logic [6:0] vram_col_q, vram_col_d;
    logic [7:0] vram_char_q, vram_char_d;

    logic [5:0] row_sum;
    logic [4:0] phys_row;
    logic       accept;
    logic       do_lf;

    // ROWS is not a power of two, so the ring offset wraps by compare-and-subtract.
    always_comb begin
        row_sum = {1'b0, top_row_q} + {1'b0, cursor_row_q};
        if (row_sum >= ROWS_W) begin
            row_sum = row_sum - ROWS_W;
        end
        phys_row = row_sum[4:0];
    end

    assign accept = in_valid_i && in_ready_q && (state_q == S_IDLE);

    always_comb begin
        state_d      = state_q;
        clr_row_d    = clr_row_q;
        clr_col_d    = clr_col_q;
        top_row_d    = top_row_q;
        cursor_row_d = cursor_row_q;
        cursor_col_d = cursor_col_q;
        in_ready_d   = in_ready_q;
        vram_we_d    = 1'b0;
        vram_row_d   = vram_row_q;
        vram_col_d   = vram_col_q;
        vram_char_d  = vram_char_q;
        do_lf        = 1'b0;

        case (state_q)
            S_CLEAR_ALL: begin
                vram_we_d   = 1'b1;
                vram_row_d  = clr_row_q;
                vram_col_d  = clr_col_q;
                vram_char_d = BLANK;
                if (clr_col_q == COL_LAST) begin
                    clr_col_d = '0;
                    if (clr_row_q == ROW_LAST) begin
                        clr_row_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        clr_row_d = clr_row_q + 5'd1;
                    end
                end else begin
                    clr_col_d = clr_col_q + 7'd1;
                end
            end

            S_CLEAR_ROW: begin
                vram_we_d   = 1'b1;
                vram_row_d  = clr_row_q;
                vram_col_d  = clr_col_q;
                vram_char_d = BLANK;
                if (clr_col_q == COL_LAST) begin
                    clr_col_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    clr_col_d = clr_col_q + 7'd1;
                end
            end

            S_IDLE: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    if (in_char_i >= 8'h20 && in_char_i <= 8'h7E) begin
                        vram_we_d   = 1'b1;
                        vram_row_d  = phys_row;
                        vram_col_d  = cursor_col_q;
                        vram_char_d = in_char_i;
                        if (cursor_col_q == COL_LAST) begin
                            cursor_col_d = '0;
                            do_lf        = 1'b1;
                        end else begin
                            cursor_col_d = cursor_col_q + 7'd1;
                        end
                    end else if (in_char_i == 8'h0A) begin
                        do_lf = 1'b1;
                    end else if (in_char_i == 8'h0D) begin
                        cursor_col_d = '0;
                    end else if (in_char_i == 8'h08) begin
                        if (cursor_col_q != 7'd0) begin
                            cursor_col_d = cursor_col_q - 7'd1;
                        end
                    end

                    // Scrolling blanks the old top row, which becomes the new bottom row.
                    if (do_lf) begin
                        if (cursor_row_q != ROW_LAST) begin
                            cursor_row_d = cursor_row_q + 5'd1;
                        end else begin
                            top_row_d  = (top_row_q == ROW_LAST) ? 5'd0 : top_row_q + 5'd1;
                            clr_row_d  = top_row_q;
                            clr_col_d  = '0;
                            state_d    = S_CLEAR_ROW;
                            in_ready_d = 1'b0;
                        end
                    end
                end
            end

            default: begin
                state_d = S_CLEAR_ALL;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_CLEAR_ALL;
            clr_row_q    <= '0;
            clr_col_q    <= '0;
            top_row_q    <= '0;
            cursor_row_q <= '0;
            cursor_col_q <= '0;
            in_ready_q   <= 1'b0;
            vram_we_q    <= 1'b0;
            vram_row_q   <= '0;
            vram_col_q   <= '0;
            vram_char_q  <= '0;
        end else begin
            state_q      <= state_d;
            clr_row_q    <= clr_row_d;
            clr_col_q    <= clr_col_d;
            top_row_q    <= top_row_d;
            cursor_row_q <= cursor_row_d;
            cursor_col_q <= cursor_col_d;
            in_ready_q   <= in_ready_d;
            vram_we_q    <= vram_we_d;
            vram_row_q   <= vram_row_d;
            vram_col_q   <= vram_col_d;
            vram_char_q  <= vram_char_d;
        end
    end

    assign in_ready_o   = in_ready_q;
    assign top_row_o    = top_row_q;
    assign cursor_row_o = cursor_row_q;
    assign cursor_col_o = cursor_col_q;
    assign vram_we_o    = vram_we_q;
    assign vram_row_o   = vram_row_q;
    assign vram_col_o   = vram_col_q;
    assign vram_char_o  = vram_char_q;

endmodule

// File: tb/tb_text_cursor.sv
// Directed bench for text_cursor: screen clear, printing, wrap, scroll, control bytes
// and reset during a row clear. Outputs are sampled on the falling edge.
module tb_text_cursor;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic [4:0] top_row;
    logic [4:0] cursor_row;
    logic [6:0] cursor_col;
    logic       vram_we;
    logic [4:0] vram_row;
    logic [6:0] vram_col;
    logic [7:0] vram_char;

    int checks = 0;
    int errors = 0;

    text_cursor dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_char_i    (in_char),
        .top_row_o    (top_row),
        .cursor_row_o (cursor_row),
        .cursor_col_o (cursor_col),
        .vram_we_o    (vram_we),
        .vram_row_o   (vram_row),
        .vram_col_o   (vram_col),
        .vram_char_o  (vram_char)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Present a byte from a falling edge; returns on the falling edge right after acceptance.
    task automatic send(input logic [7:0] c, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_char  = c;
        for (int k = 0; k < 5000; k++) begin
            if (in_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n = 0, mism = 0, gaps = 0;
        logic [4:0] er = 0;
        logic [6:0] ec = 0;
        bit prev_we = 0, ready_we = 1, done = 0;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_char  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, vram_we} !== 2'b00) begin
            errors++; $display("FAIL reset_ready_we: got %b exp 00", {in_ready, vram_we});
        end
        checks++;
        if ({vram_row, vram_col, vram_char} !== 20'h0) begin
            errors++; $display("FAIL reset_vram_addr: got %h exp 0", {vram_row, vram_col, vram_char});
        end
        checks++;
        if ({top_row, cursor_row, cursor_col} !== 17'h0) begin
            errors++; $display("FAIL reset_cursor: got %h exp 0", {top_row, cursor_row, cursor_col});
        end
        reset = 1'b0;
        for (int cyc = 0; cyc < 3200; cyc++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1; ready_we = vram_we; in_valid = 1'b0;
                break;
            end
            if (vram_we) begin
                if (vram_row !== er || vram_col !== ec || vram_char !== 8'h20) mism++;
                n++;
                if (ec == 7'd99) begin ec = 0; er++; end else ec++;
            end else gaps++;
            prev_we = vram_we;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL clear_all_ready: got 0 exp 1 (timeout)"); end
        checks++;
        if (n != 3000) begin errors++; $display("FAIL clear_all_count: got %0d exp 3000", n); end
        checks++;
        if (mism != 0) begin errors++; $display("FAIL clear_all_seq: got %0d bad writes exp 0", mism); end
        checks++;
        if (gaps != 0) begin errors++; $display("FAIL clear_all_gaps: got %0d idle cycles exp 0", gaps); end
        checks++;
        if ({prev_we, ready_we} !== 2'b10) begin
            errors++; $display("FAIL clear_all_ready_timing: got we_prev/we_now %b exp 10", {prev_we, ready_we});
        end
        checks++;
        if ({top_row, cursor_row, cursor_col} !== 17'h0) begin
            errors++; $display("FAIL clear_all_cursor: got %h exp 0", {top_row, cursor_row, cursor_col});
        end
    endtask

    task automatic test_back_to_back();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ab_ready: got %b exp 1", in_ready); end
        in_valid = 1'b1;
        in_char  = 8'h41;
        @(negedge clk);
        checks++;
        if ({vram_we, vram_row, vram_col, vram_char} !== {1'b1, 5'd0, 7'd0, 8'h41}) begin
            errors++; $display("FAIL ab_write_A: got %h exp %h",
                               {vram_we, vram_row, vram_col, vram_char}, {1'b1, 5'd0, 7'd0, 8'h41});
        end
        in_char = 8'h42;
        @(negedge clk);
        checks++;
        if ({vram_we, vram_row, vram_col, vram_char} !== {1'b1, 5'd0, 7'd1, 8'h42}) begin
            errors++; $display("FAIL ab_write_B: got %h exp %h",
                               {vram_we, vram_row, vram_col, vram_char}, {1'b1, 5'd0, 7'd1, 8'h42});
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({vram_we, cursor_row, cursor_col} !== {1'b0, 5'd0, 7'd2}) begin
            errors++; $display("FAIL ab_cursor: got we/row/col %h exp %h",
                               {vram_we, cursor_row, cursor_col}, {1'b0, 5'd0, 7'd2});
        end
    endtask

    task automatic test_wrap();
        bit ok, all_ok = 1;
        int bad = 0;
        send(8'h0D, ok); all_ok &= ok;
        for (int i = 0; i < 5; i++) begin send(8'h0A, ok); all_ok &= ok; end
        for (int i = 0; i < 99; i++) begin send(8'h2E, ok); all_ok &= ok; end
        in_valid = 1'b0;
        checks++;
        if ({cursor_row, cursor_col} !== {5'd5, 7'd99}) begin
            errors++; $display("FAIL wrap_setup: got %0d,%0d exp 5,99", cursor_row, cursor_col);
        end
        send(8'h5A, ok); all_ok &= ok;
        in_valid = 1'b0;
        checks++;
        if ({vram_we, vram_row, vram_col, vram_char} !== {1'b1, 5'd5, 7'd99, 8'h5A}) begin
            errors++; $display("FAIL wrap_write: got %h exp %h",
                               {vram_we, vram_row, vram_col, vram_char}, {1'b1, 5'd5, 7'd99, 8'h5A});
        end
        checks++;
        if ({in_ready, cursor_row, cursor_col} !== {1'b1, 5'd6, 7'd0}) begin
            errors++; $display("FAIL wrap_cursor: got rdy/row/col %b,%0d,%0d exp 1,6,0",
                               in_ready, cursor_row, cursor_col);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (vram_we || !in_ready) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL wrap_no_clear: got %0d bad cycles exp 0", bad); end
        checks++;
        if (!all_ok) begin errors++; $display("FAIL wrap_send: got timeout exp accept"); end
    endtask

    task automatic test_scroll();
        bit ok, all_ok = 1, done = 0, prev_we = 0;
        int n = 0, mism = 0, gaps = 0;
        logic [6:0] ec = 0;
        for (int i = 0; i < 23; i++) begin send(8'h0A, ok); all_ok &= ok; end
        for (int i = 0; i < 29; i++) begin send(8'h0A, ok); all_ok &= ok; end
        send(8'h0D, ok); all_ok &= ok;
        for (int i = 0; i < 10; i++) begin send(8'h61, ok); all_ok &= ok; end
        in_valid = 1'b0;
        checks++;
        if ({top_row, cursor_row, cursor_col} !== {5'd29, 5'd29, 7'd10}) begin
            errors++; $display("FAIL scroll_setup: got top/row/col %0d,%0d,%0d exp 29,29,10",
                               top_row, cursor_row, cursor_col);
        end
        send(8'h0A, ok); all_ok &= ok;
        in_valid = 1'b0;
        checks++;
        if ({in_ready, vram_we, top_row, cursor_row} !== {1'b0, 1'b0, 5'd0, 5'd29}) begin
            errors++; $display("FAIL scroll_first_cycle: got rdy/we/top/row %b,%b,%0d,%0d exp 0,0,0,29",
                               in_ready, vram_we, top_row, cursor_row);
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (in_ready) begin done = 1; break; end
            if (vram_we) begin
                if (vram_row !== 5'd29 || vram_col !== ec || vram_char !== 8'h20) mism++;
                n++; ec++;
            end else gaps++;
            prev_we = vram_we;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL scroll_ready: got 0 exp 1 (timeout)"); end
        checks++;
        if (n != 100) begin errors++; $display("FAIL scroll_clear_count: got %0d exp 100", n); end
        checks++;
        if (mism != 0 || gaps != 0) begin
            errors++; $display("FAIL scroll_clear_seq: got %0d bad, %0d gaps exp 0,0", mism, gaps);
        end
        checks++;
        if (prev_we !== 1'b1) begin errors++; $display("FAIL scroll_ready_timing: got %b exp 1", prev_we); end
        checks++;
        if ({top_row, cursor_row, cursor_col} !== {5'd0, 5'd29, 7'd10}) begin
            errors++; $display("FAIL scroll_after: got top/row/col %0d,%0d,%0d exp 0,29,10",
                               top_row, cursor_row, cursor_col);
        end
        checks++;
        if (!all_ok) begin errors++; $display("FAIL scroll_send: got timeout exp accept"); end
    endtask

    task automatic test_control();
        bit ok, all_ok = 1;
        send(8'h0D, ok); all_ok &= ok;
        checks++;
        if ({vram_we, cursor_col} !== {1'b0, 7'd0}) begin
            errors++; $display("FAIL ctrl_cr: got we/col %b,%0d exp 0,0", vram_we, cursor_col);
        end
        send(8'h08, ok); all_ok &= ok;
        checks++;
        if ({vram_we, cursor_col} !== {1'b0, 7'd0}) begin
            errors++; $display("FAIL ctrl_bs_col0: got we/col %b,%0d exp 0,0", vram_we, cursor_col);
        end
        send(8'h07, ok); all_ok &= ok;
        checks++;
        if ({vram_we, top_row, cursor_row, cursor_col} !== {1'b0, 5'd0, 5'd29, 7'd0}) begin
            errors++; $display("FAIL ctrl_other: got we/top/row/col %b,%0d,%0d,%0d exp 0,0,29,0",
                               vram_we, top_row, cursor_row, cursor_col);
        end
        send(8'h51, ok); all_ok &= ok;
        checks++;
        if ({vram_we, vram_row, vram_col, vram_char, cursor_col} !== {1'b1, 5'd29, 7'd0, 8'h51, 7'd1}) begin
            errors++; $display("FAIL ctrl_print: got %h exp %h", {vram_we, vram_row, vram_col, vram_char, cursor_col},
                               {1'b1, 5'd29, 7'd0, 8'h51, 7'd1});
        end
        send(8'h08, ok); all_ok &= ok;
        in_valid = 1'b0;
        checks++;
        if ({vram_we, cursor_col} !== {1'b0, 7'd0}) begin
            errors++; $display("FAIL ctrl_bs: got we/col %b,%0d exp 0,0", vram_we, cursor_col);
        end
        checks++;
        if (!all_ok) begin errors++; $display("FAIL ctrl_send: got timeout exp accept"); end
    endtask

    task automatic test_reset_mid_clear();
        bit ok;
        int n = 0, mism = 0;
        logic [4:0] er = 0;
        logic [6:0] ec = 0;
        send(8'h0A, ok);
        in_valid = 1'b0;
        checks++;
        if (!ok || top_row !== 5'd1) begin
            errors++; $display("FAIL mid_scroll_start: got ok/top %b,%0d exp 1,1", ok, top_row);
        end
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (vram_we) n++;
            if (n == 50) break;
        end
        checks++;
        if (n != 50) begin errors++; $display("FAIL mid_clear_count: got %0d exp 50", n); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, vram_we, top_row, cursor_row, cursor_col} !== 19'h0) begin
            errors++; $display("FAIL mid_reset_state: got %h exp 0", {in_ready, vram_we, top_row, cursor_row, cursor_col});
        end
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!vram_we || vram_row !== er || vram_col !== ec || vram_char !== 8'h20 ||
                top_row !== 5'd0 || in_ready) mism++;
            if (ec == 7'd99) begin ec = 0; er++; end else ec++;
        end
        checks++;
        if (mism != 0) begin errors++; $display("FAIL mid_restart_seq: got %0d bad cycles exp 0", mism); end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_char  = 8'h00;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_wrap();
        test_scroll();
        test_control();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
